// File: rtl/cic_interp.sv
// rtl/cic_interp.sv - Multi-stage I/Q CIC interpolator with valid/ready on both sides.
// Optional round-and-saturate output scaling is enabled by defining CIC_INTERP_ROUND_EN.
module cic_interp #(
    parameter int WIDTH  = 16,
    parameter int FACTOR = 313,
    parameter int DELAY  = 2,
    parameter int STAGES = 5
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_inph_data,
    input  logic [WIDTH-1:0] i_quad_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_inph_data,
    output logic [WIDTH-1:0] o_quad_data,
    output logic             o_valid,
    input  logic             i_ready
);
    localparam int GROWTH = STAGES * $clog2(FACTOR * DELAY);
    localparam int ACC_W  = WIDTH + GROWTH;
    localparam int PH_W   = $clog2(FACTOR);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(FACTOR - 1);

    logic            r_h_valid;
    logic            r_o_valid;
    logic [PH_W-1:0] r_phase;
    logic            w_accept;
    logic            w_step;
    logic            w_last;

    assign w_last   = (r_phase == PH_LAST);
    assign w_step   = r_h_valid && (!r_o_valid || i_ready);
    // A new sample may land in the hold register on the very step that consumes its last phase.
    assign o_ready  = !r_h_valid || (w_step && w_last);
    assign w_accept = i_valid && o_ready;
    assign o_valid  = r_o_valid;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_h_valid <= 1'b0;
            r_o_valid <= 1'b0;
            r_phase   <= '0;
        end else begin
            if (w_accept)
                r_h_valid <= 1'b1;
            else if (w_step && w_last)
                r_h_valid <= 1'b0;

            if (w_step) begin
                r_o_valid <= 1'b1;
                r_phase   <= w_last ? '0 : r_phase + 1'b1;
            end else if (i_ready) begin
                r_o_valid <= 1'b0;
            end
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic signed [WIDTH-1:0] w_x;
        logic signed [ACC_W-1:0] w_comb [STAGES+1];
        logic signed [ACC_W-1:0] r_dly  [STAGES][DELAY];
        logic signed [ACC_W-1:0] r_hold;
        logic signed [ACC_W-1:0] w_u;
        logic signed [ACC_W-1:0] r_int  [STAGES];
        logic signed [ACC_W-1:0] w_int  [STAGES];
        logic signed [WIDTH-1:0] w_scaled;
        logic signed [WIDTH-1:0] r_out;

        assign w_x = (ch == 0) ? i_inph_data : i_quad_data;
        assign w_u = (r_phase == '0) ? r_hold : '0;

        always_comb begin
            w_comb[0] = {{GROWTH{w_x[WIDTH-1]}}, w_x};
            for (int k = 0; k < STAGES; k++)
                w_comb[k+1] = w_comb[k] - r_dly[k][DELAY-1];
            w_int[0] = r_int[0] + w_u;
            for (int k = 1; k < STAGES; k++)
                w_int[k] = r_int[k] + w_int[k-1];
        end

`ifdef CIC_INTERP_ROUND_EN
        localparam int SW = ACC_W + 1;
        localparam logic [SW-1:0] RND_K = SW'(1) << (GROWTH - 1);
        logic [SW-1:0] w_rnd;

        assign w_rnd = {w_int[STAGES-1][ACC_W-1], w_int[STAGES-1]} + RND_K;

        // The shifted result has WIDTH+1 significant bits; a sign mismatch on the top two means overflow.
        always_comb begin
            if (w_rnd[SW-1] != w_rnd[SW-2])
                w_scaled = w_rnd[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else
                w_scaled = w_rnd[SW-2 -: WIDTH];
        end
`else
        assign w_scaled = w_int[STAGES-1][ACC_W-1 -: WIDTH];
`endif

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                for (int k = 0; k < STAGES; k++) begin
                    for (int j = 0; j < DELAY; j++)
                        r_dly[k][j] <= '0;
                    r_int[k] <= '0;
                end
                r_hold <= '0;
                r_out  <= '0;
            end else begin
                if (w_accept) begin
                    for (int k = 0; k < STAGES; k++) begin
                        r_dly[k][0] <= w_comb[k];
                        for (int j = 1; j < DELAY; j++)
                            r_dly[k][j] <= r_dly[k][j-1];
                    end
                    r_hold <= w_comb[STAGES];
                end
                if (w_step) begin
                    for (int k = 0; k < STAGES; k++)
                        r_int[k] <= w_int[k];
                    r_out <= w_scaled;
                end
            end
        end
    end

    assign o_inph_data = g_ch[0].r_out;
    assign o_quad_data = g_ch[1].r_out;
endmodule

// File: tb/tb_cic_interp.sv
// tb/tb_cic_interp.sv - Directed bench for cic_interp: small config (R=4,M=1,N=1) and default config.
// Expected values follow the CIC_INTERP_ROUND_EN setting of the build.
module tb_cic_interp;
`ifdef CIC_INTERP_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif
    localparam int NB = 11 * 313;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic a_vi, a_ro, a_vo, a_ri;
    logic signed [15:0] a_di, a_dq, a_oi, a_oq;
    logic b_vi, b_ro, b_vo, b_ri;
    logic signed [15:0] b_di, b_dq, b_oi, b_oq;

    cic_interp #(.WIDTH(16), .FACTOR(4), .DELAY(1), .STAGES(1)) u_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_inph_data(a_di), .i_quad_data(a_dq),
        .i_valid(a_vi), .o_ready(a_ro), .o_inph_data(a_oi), .o_quad_data(a_oq),
        .o_valid(a_vo), .i_ready(a_ri));

    cic_interp u_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_inph_data(b_di), .i_quad_data(b_dq),
        .i_valid(b_vi), .o_ready(b_ro), .o_inph_data(b_oi), .o_quad_data(b_oq),
        .o_valid(b_vo), .i_ready(b_ri));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int qa_i[$], qa_q[$], qa_t[$];
    int qb_i[$], qb_q[$];
    longint hm[NB], hn[NB];
    int ei[NB], eq[NB];

    always @(negedge clk) begin
        cyc++;
        if (a_vo && a_ri) begin
            qa_i.push_back(int'(a_oi));
            qa_q.push_back(int'(a_oq));
            qa_t.push_back(cyc);
        end
        if (b_vo && b_ri) begin
            qb_i.push_back(int'(b_oi));
            qb_q.push_back(int'(b_oq));
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        qa_i.delete(); qa_q.delete(); qa_t.delete();
        qb_i.delete(); qb_q.delete();
    endtask

    task automatic push(input bit sel, input int vi, input int vq);
        int n = 0;
        if (!sel) begin
            a_vi = 1'b1; a_di = vi[15:0]; a_dq = vq[15:0];
            while (!a_ro && n < 2000) begin tick(); n++; end
        end else begin
            b_vi = 1'b1; b_di = vi[15:0]; b_dq = vq[15:0];
            while (!b_ro && n < 2000) begin tick(); n++; end
        end
        chk("push_timeout", (n < 2000) ? 1 : 0, 1);
        tick();
        a_vi = 1'b0;
        b_vi = 1'b0;
    endtask

    task automatic chk_imp(input string tag, input int e_i, input int e_q);
        chk({tag, "_count"}, qa_i.size(), 8);
        for (int k = 0; k < 8 && k < qa_i.size(); k++) begin
            chk({tag, "_i"}, qa_i[k], (k < 4) ? e_i : 0);
            chk({tag, "_q"}, qa_q[k], (k < 4) ? e_q : 0);
        end
    endtask

    initial begin
        int bad;
        longint acc, x, sum_d, sum_m;

        // Reference: high-rate impulse response is STAGES boxcars of length R*M = 626.
        for (int n = 0; n < NB; n++) hm[n] = 0;
        hm[0] = 1;
        for (int s = 0; s < 5; s++) begin
            acc = 0;
            for (int n = 0; n < NB; n++) begin
                acc += hm[n];
                if (n >= 626) acc -= hm[n-626];
                hn[n] = acc;
            end
            for (int n = 0; n < NB; n++) hm[n] = hn[n];
        end
        for (int n = 0; n < NB; n++) begin
            x = 64'sd1000 * hm[n];
            ei[n] = ROUND ? int'((x + (64'sd1 <<< 49)) >>> 50) : int'(x >>> 50);
            eq[n] = ROUND ? int'((-x + (64'sd1 <<< 49)) >>> 50) : int'((-x) >>> 50);
        end

        rst_n = 1'b0;
        a_vi = 0; a_di = 0; a_dq = 0; a_ri = 1;
        b_vi = 0; b_di = 0; b_dq = 0; b_ri = 1;
        tick(); tick();
        chk("rst_ovalid", a_vo, 0);
        chk("rst_odata_i", a_oi, 0);
        chk("rst_odata_q", a_oq, 0);
        chk("rst_oready", a_ro, 1);
        chk("rst_b_ovalid", b_vo, 0);
        rst_n = 1'b1;
        tick();

        clear_q();
        push(0, 400, -400);
        chk("lat_accept_cycle", a_vo, 0);
        tick();
        chk("lat_first_valid", a_vo, 1);
        chk("lat_first_data", a_oi, 100);
        push(0, 0, 0);
        repeat (6) tick();
        chk_imp("imp400", 100, -100);

        clear_q();
        for (int k = 0; k < 8; k++) push(0, 400, -400);
        push(0, 0, 0);
        repeat (6) tick();
        chk("dc_count", qa_i.size(), 36);
        for (int k = 0; k < 36 && k < qa_i.size(); k++) begin
            chk("dc_i", qa_i[k], (k < 32) ? 100 : 0);
            chk("dc_q", qa_q[k], (k < 32) ? -100 : 0);
        end
        if (qa_t.size() == 36) chk("dc_gapless", qa_t[35] - qa_t[0], 35);

        clear_q();
        push(0, 2, -2);
        push(0, 0, 0);
        repeat (6) tick();
        chk_imp("small2", ROUND ? 1 : 0, ROUND ? 0 : -1);

        clear_q();
        push(0, 32767, -32767);
        push(0, 0, 0);
        repeat (6) tick();
        chk_imp("fullscale", ROUND ? 8192 : 8191, -8192);

        clear_q();
        push(0, 400, -400);
        tick(); tick();
        a_ri = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_ovalid", a_vo, 1);
            chk("bp_data_i", a_oi, 100);
            chk("bp_data_q", a_oq, -100);
            chk("bp_oready", a_ro, 0);
        end
        a_ri = 1'b1;
        push(0, 0, 0);
        repeat (6) tick();
        chk_imp("bp", 100, -100);

        push(0, 400, -400);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ovalid", a_vo, 0);
        chk("mrst_data_i", a_oi, 0);
        chk("mrst_data_q", a_oq, 0);
        chk("mrst_oready", a_ro, 1);
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
        push(0, 400, -400);
        push(0, 0, 0);
        repeat (6) tick();
        chk_imp("post_rst", 100, -100);

        clear_q();
        push(1, 1000, -1000);
        for (int k = 0; k < 10; k++) push(1, 0, 0);
        repeat (330) tick();
        chk("def_count", qb_i.size(), NB);
        bad = 0;
        sum_d = 0;
        sum_m = 0;
        for (int n = 0; n < NB && n < qb_i.size(); n++) begin
            if (qb_i[n] != ei[n] || qb_q[n] != eq[n]) bad++;
            sum_d += qb_i[n] + qb_q[n];
            sum_m += ei[n] + eq[n];
        end
        chk("def_sample_mismatches", bad, 0);
        chk("def_sum", sum_d, sum_m);
        bad = 0;
        for (int n = 3130; n < NB && n < qb_i.size(); n++)
            if (qb_i[n] != 0 || qb_q[n] != 0) bad++;
        chk("def_tail_zero", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cic_interp.md
Name: cic_interp

Overview:
- Multi-stage CIC interpolator for complex (I/Q) baseband; the transmit-side counterpart of the CIC decimator.
- Accepts one low-rate I/Q sample per input handshake and emits FACTOR high-rate I/Q samples per input.
- Comb stages run at the low rate; zero-stuffing upsampler; integrator stages run at the high rate; output is scaled back to WIDTH.
- Valid/ready on both sides; output rate is set by the downstream consumer.

Parameters:
- WIDTH, 16: I and Q sample width, signed two's complement, input and output.
- FACTOR, 313: interpolation ratio R, ≥ 2.
- DELAY, 2: comb differential delay M, ≥ 1.
- STAGES, 5: number of comb stages and number of integrator stages N, ≥ 1.
- (localparam) GROWTH = STAGES*$clog2(FACTOR*DELAY); ACC_W = WIDTH+GROWTH.

Ports:
- i_clock  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_inph_data  in  WIDTH  input I sample.
- i_quad_data  in  WIDTH  input Q sample.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept an input sample this cycle.
- o_inph_data  out  WIDTH  output I sample.
- o_quad_data  out  WIDTH  output Q sample.
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream accepts the output sample.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While i_reset_n=0, all of the following are 0: comb delay lines, hold register, h_valid, phase counter, integrators, o_valid, o_inph_data, o_quad_data. o_ready=1 after reset. Asserting reset mid-burst discards the pending sample and all filter state.
- Arithmetic:
  - All internal arithmetic is ACC_W bits signed; input is sign-extended.
  - Integrators wrap modulo 2^ACC_W. Wrap is intentional and must not saturate.
- Input accept: accept = i_valid && o_ready. On accept:
  - Comb chain is computed combinationally: c0 = x; ck = c(k-1) - c(k-1) delayed by DELAY accepts.
  - Each comb delay line shifts by one.
  - Hold register h <= c(STAGES); h_valid <= 1.
- Step: step = h_valid && (!o_valid || i_ready). On step:
  - Integrator input u = (phase==0) ? h : 0.
  - Integrators update as a combinational chain: s0 <= s0+u; sk <= sk + s(k-1)_new.
  - Output register <= scale(s(STAGES-1)_new); o_valid <= 1.
  - phase <= (phase==FACTOR-1) ? 0 : phase+1.
- Output drop: if !step && i_ready, then o_valid <= 0.
- Output data: held stable while o_valid && !i_ready.
- Latency: 1 cycle from input accept to first o_valid. Subsequent outputs are one per cycle while i_ready=1.
- o_ready = !h_valid || (step && phase==FACTOR-1). This is a combinational path from i_ready; back-to-back inputs give gapless output.
- Last phase with no new accept: h_valid <= 0. Accept on the last-phase step: h reloads and h_valid stays 1.
- scale(): output is s(STAGES-1)[ACC_W-1 -: WIDTH], plain truncation toward −inf. DC gain is (R·M)^N / R / 2^GROWTH.
- i_valid with o_ready=0: the input is ignored; the upstream source must hold it.
- Phase counter width: $clog2(FACTOR).
- I and Q paths are identical and fully independent.

Optional Feature:
- Macro: CIC_INTERP_ROUND_EN.
- Defined: scale() adds 2^(GROWTH-1) to s(STAGES-1)_new before the slice, then saturates to [−2^(WIDTH-1), 2^(WIDTH-1)−1] when the rounded value overflows WIDTH.
- Undefined: plain truncation as above; no rounding or saturation logic is instantiated.

Test Plan:
- Config WIDTH=16, STAGES=1, DELAY=1, FACTOR=4 (GROWTH=2), i_ready=1:
  - Inputs I=400 then I=0 -> outputs 100,100,100,100,0,0,0,0; first o_valid 1 cycle after the first accept.
  - Constant DC I=400, Q=−400 held for 8 inputs -> steady outputs I=100, Q=−100 every cycle; o_ready pulses once per 4 cycles with no output gaps.
- Same config, single input I=2:
  - Macro undefined -> outputs 0,0,0,0.
  - CIC_INTERP_ROUND_EN defined -> outputs 1,1,1,1.
  - Input I=0x7FFF with the macro defined -> outputs 0x2000, no saturation flag error.
- Backpressure: drop i_ready for 5 cycles mid-burst -> o_valid stays 1, o_inph_data/o_quad_data stable, phase frozen, o_ready=0. After release, sequence resumes with no lost or duplicated samples.
- Reset mid-burst: deassert i_reset_n asynchronously at phase 2 -> o_valid and data go 0 immediately, o_ready=1 after release; the next impulse reproduces the clean impulse response.
- Default params, impulse I=1000 with WIDTH growth check -> output sum over all 313·(N·M) samples equals the analytical DC-gain-scaled value (reference model), and the integrators return to exactly 0 after the response.
